pll_reconfig_seq: RTL and testbench
===================================

PLL_RECONFIG_SEQ -- requirements
Module: pll_reconfig_seq

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1023: maximum clk cycles spent waiting in any single handshake phase.
REQ-002 SHALL have port clk, input, 1: the single clock, the core system clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port req, input, 1: reconfiguration request, sampled only when ready=1.
REQ-005 SHALL have ports m_val, n_val, c0_val, k_val, input, 32 each: the PLL counter words, captured on an accepted req.
REQ-006 SHALL have port ready, output, 1: high when idle and able to accept req.
REQ-007 SHALL have port done, output, 1: one-cycle pulse on successful completion.
REQ-008 SHALL have port err, output, 1: high after a timeout abort; held until the next accepted req or reset.
REQ-009 SHALL have port pll_addr, output, 6: reconfiguration register address.
REQ-010 SHALL have port pll_value, output, 32: reconfiguration write data.
REQ-011 SHALL have port pll_write, output, 1: write strobe, level-held until it is acknowledged.
REQ-012 SHALL have port pll_busy, input, 1: busy from the CLK_50M domain, asynchronous to clk.

Function
REQ-013 SHALL pass pll_busy through a 2-flop synchronizer (busy_s) before any use; busy_s resets to 1.
REQ-014 SHALL accept req only when ready=1 and req=1, capturing all four counter words, clearing err and setting ready=0 on the following cycle.
REQ-015 SHALL issue exactly six writes, in this order: (0, 0x0) mode=waitrequest; (4, m_val); (3, n_val); (5, c0_val); (7, k_val); (2, 0x0) start.
REQ-016 SHALL run each write as three phases. SETUP: drive addr/value with pll_write=0 for 1 cycle. STROBE: pll_write=1 until busy_s=1. RELEASE: pll_write=0 until busy_s=0.
REQ-017 SHALL hold pll_addr and pll_value stable from SETUP through the end of RELEASE.
REQ-018 SHALL enter a pre-start WAIT_IDLE state after accept and before the first SETUP, waiting for busy_s=0.
REQ-019 SHALL use states IDLE, WAIT_IDLE, SETUP, STROBE, RELEASE, FINISH; RELEASE of write 6 goes to FINISH, and FINISH pulses done for 1 cycle then returns to IDLE.
REQ-020 SHALL reload a phase counter to 0 on entry to WAIT_IDLE, STROBE and RELEASE; when it reaches TIMEOUT without the exit condition, it SHALL set err=1, pll_write=0 and return to IDLE with no done.
REQ-021 SHALL ignore req while ready=0; there is no queuing.
REQ-022 SHALL keep the captured words constant during a sequence when input words change mid-sequence.
REQ-023 SHALL make ready=1 in the same cycle the FSM is in IDLE; done and err never assert in the same cycle.
REQ-024 SHALL keep a 3-bit write index that wraps to 0 only on entry to IDLE.

Reset
REQ-025 SHALL force, on reset=1 (synchronous, any state including mid-handshake): state=IDLE, pll_write=0, pll_addr=0, pll_value=0, done=0, err=0, index=0, counters=0 and busy sync flops=1.
REQ-026 SHALL make ready read 0 during the reset cycle and 1 from the first cycle after reset deasserts.

Verification
REQ-027 Nominal: the bench SHALL model busy rising 3 clk after pll_write rises and falling 20 clk after pll_write falls; with req and m_val=0x00000404 -> six writes at addresses 0,4,3,5,7,2 with matching data, one done pulse, err=0.
REQ-028 Timeout: with pll_busy stuck 0 during the STROBE of write 2 -> err=1 after TIMEOUT+1 cycles in STROBE, pll_write=0, no done, ready=1.
REQ-029 Busy-at-start: with pll_busy=1 for 500 cycles before req -> no pll_write until busy_s=0, then the normal sequence completes.
REQ-030 Mid-sequence reset: asserting reset while in STROBE of write 4 -> the next cycle shows pll_write=0 and state IDLE; a new req then performs all six writes from address 0.
REQ-031 Request during busy: a second req with different words while ready=0 -> it is ignored and the first words are written unchanged.
REQ-032 Hold check: the bench SHALL assert pll_addr and pll_value never change while pll_write=1 or busy_s=1 within a write.

Source files
------------

// File: rtl/pll_reconfig_seq.sv
// Sequences the six-write PLL reconfiguration handshake (mode, M, N, C0, K, start)
// against a busy flag that lives in another clock domain; any stalled phase aborts with err.
module pll_reconfig_seq #(
  parameter int TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [31:0] m_val,
  input  logic [31:0] n_val,
  input  logic [31:0] c0_val,
  input  logic [31:0] k_val,
  output logic        ready,
  output logic        done,
  output logic        err,
  output logic [5:0]  pll_addr,
  output logic [31:0] pll_value,
  output logic        pll_write,
  input  logic        pll_busy
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [2:0]    LAST_IDX = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_IDLE = 3'd1,
    S_SETUP     = 3'd2,
    S_STROBE    = 3'd3,
    S_RELEASE   = 3'd4,
    S_FINISH    = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   m_q, n_q, c0_q, k_q;
  logic          sync1_q, busy_s_q;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          write_q, write_d;
  logic [5:0]    addr_q, addr_d;
  logic [31:0]   value_q, value_d;
  logic          capture;
  logic          abort;

  // Register address for each step of the write sequence.
  function automatic logic [5:0] wr_addr(input logic [2:0] idx);
    logic [5:0] a;
    case (idx)
      3'd0:    a = 6'd0;
      3'd1:    a = 6'd4;
      3'd2:    a = 6'd3;
      3'd3:    a = 6'd5;
      3'd4:    a = 6'd7;
      3'd5:    a = 6'd2;
      default: a = 6'd0;
    endcase
    return a;
  endfunction

  function automatic logic [31:0] wr_data(input logic [2:0]  idx,
                                          input logic [31:0] m,
                                          input logic [31:0] n,
                                          input logic [31:0] c0,
                                          input logic [31:0] k);
    logic [31:0] d;
    case (idx)
      3'd1:    d = m;
      3'd2:    d = n;
      3'd3:    d = c0;
      3'd4:    d = k;
      default: d = 32'd0;
    endcase
    return d;
  endfunction

  // busy comes from the 50 MHz domain; resetting the flops to 1 treats the PLL as busy until proven idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= 1'b1;
      busy_s_q <= 1'b1;
    end else begin
      sync1_q  <= pll_busy;
      busy_s_q <= sync1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= CNT_ZERO;
      idx_q   <= 3'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= 6'd0;
      value_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      err_q   <= err_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      value_q <= value_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_q  <= 32'd0;
      n_q  <= 32'd0;
      c0_q <= 32'd0;
      k_q  <= 32'd0;
    end else if (capture) begin
      m_q  <= m_val;
      n_q  <= n_val;
      c0_q <= c0_val;
      k_q  <= k_val;
    end else begin
      m_q  <= m_q;
      n_q  <= n_q;
      c0_q <= c0_q;
      k_q  <= k_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    capture = 1'b0;
    abort   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          capture = 1'b1;
          state_d = S_WAIT_IDLE;
          cnt_d   = CNT_ZERO;
          idx_d   = 3'd0;
        end else begin
          idx_d   = 3'd0;
        end
      end
      S_WAIT_IDLE: begin
        if (!busy_s_q) begin
          state_d = S_SETUP;
        end else if (cnt_q == CNT_MAX) begin
          abort   = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      S_SETUP: begin
        state_d = S_STROBE;
        cnt_d   = CNT_ZERO;
      end
      S_STROBE: begin
        if (busy_s_q) begin
          state_d = S_RELEASE;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_MAX) begin
          abort   = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      S_RELEASE: begin
        if (!busy_s_q) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_FINISH;
          end else begin
            state_d = S_SETUP;
            idx_d   = idx_q + 3'd1;
          end
        end else if (cnt_q == CNT_MAX) begin
          abort   = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
        idx_d   = 3'd0;
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = 3'd0;
        cnt_d   = CNT_ZERO;
      end
    endcase
    if (abort) begin
      state_d = S_IDLE;
      idx_d   = 3'd0;
      cnt_d   = CNT_ZERO;
    end else begin
      state_d = state_d;
    end
  end

  // Outputs are registered from the next state so they line up with the state they belong to.
  always_comb begin
    write_d = (state_d == S_STROBE);
    done_d  = (state_d == S_FINISH);
    addr_d  = addr_q;
    value_d = value_q;
    if (capture) begin
      err_d = 1'b0;
    end else if (abort) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
    if ((state_d == S_SETUP) && (state_q != S_SETUP)) begin
      addr_d  = wr_addr(idx_d);
      value_d = wr_data(idx_d, m_q, n_q, c0_q, k_q);
    end else begin
      addr_d  = addr_q;
      value_d = value_q;
    end
  end

  assign ready     = (state_q == S_IDLE) && !reset;
  assign done      = done_q;
  assign err       = err_q;
  assign pll_write = write_q;
  assign pll_addr  = addr_q;
  assign pll_value = value_q;

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Randomized scoreboard bench for pll_reconfig_seq: a busy-flag PLL model, an expected-write
// queue filled from the write table, and a negedge monitor that pops and compares each strobe.
module tb_pll_reconfig_seq;
  localparam int TO = 1023;

  logic        clk;
  logic        reset;
  logic        req;
  logic [31:0] m_val, n_val, c0_val, k_val;
  logic        ready, done, err;
  logic [5:0]  pll_addr;
  logic [31:0] pll_value;
  logic        pll_write;
  logic        pll_busy;

  pll_reconfig_seq #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req),
    .m_val(m_val), .n_val(n_val), .c0_val(c0_val), .k_val(k_val),
    .ready(ready), .done(done), .err(err),
    .pll_addr(pll_addr), .pll_value(pll_value), .pll_write(pll_write),
    .pll_busy(pll_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { logic [5:0] a; logic [31:0] d; } wr_t;
  wr_t exp_wr[$];
  int  exp_done = 0;
  int  n_vec = 0;
  int  n_bad = 0;

  int  strobe_no = 0;
  int  stuck_at = 0;
  bit  stuck = 1'b0;
  bit  busy_force = 1'b0;
  int  last_run = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: the write table, truncated to the writes the scenario is expected to strobe.
  function automatic void push_seq(input logic [31:0] m, input logic [31:0] n,
                                   input logic [31:0] c0, input logic [31:0] k, input int nwr);
    logic [5:0]  at [6];
    logic [31:0] dt [6];
    wr_t e;
    at = '{6'd0, 6'd4, 6'd3, 6'd5, 6'd7, 6'd2};
    dt = '{32'd0, m, n, c0, k, 32'd0};
    for (int i = 0; i < nwr; i++) begin
      e.a = at[i];
      e.d = dt[i];
      exp_wr.push_back(e);
    end
  endfunction

  // PLL model: busy rises 3 clk after the strobe rises, falls 20 clk after it drops.
  initial begin
    int  hi;
    int  lo;
    logic wr_prev;
    hi = 0; lo = 0; wr_prev = 1'b0;
    pll_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (pll_write && !wr_prev) begin
        strobe_no++;
        if (strobe_no == stuck_at) stuck = 1'b1;
      end
      wr_prev = pll_write;
      if (busy_force) begin
        pll_busy = 1'b1;
      end else if (stuck) begin
        pll_busy = 1'b0;
      end else if (pll_write) begin
        lo = 0;
        hi++;
        if (hi >= 3) pll_busy = 1'b1;
      end else begin
        hi = 0;
        if (pll_busy) begin
          lo++;
          if (lo >= 20) begin
            pll_busy = 1'b0;
            lo = 0;
          end
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every strobe, checks data hold and done pulses.
  initial begin
    logic        prev_wr, prev_done, hold_on;
    logic [5:0]  ha;
    logic [31:0] hd;
    int          run;
    wr_t         e;
    prev_wr = 1'b0; prev_done = 1'b0; hold_on = 1'b0; ha = 6'd0; hd = 32'd0; run = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        hold_on = 1'b0;
        run = 0;
      end else begin
        if (pll_write && !prev_wr) begin
          if (exp_wr.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL unexpected_strobe: got addr 0x%0h data 0x%0h, expected no write", pll_addr, pll_value);
          end else begin
            e = exp_wr.pop_front();
            check("strobe_addr", {58'd0, pll_addr}, {58'd0, e.a});
            check("strobe_data", {32'd0, pll_value}, {32'd0, e.d});
          end
          hold_on = 1'b1;
          ha = pll_addr;
          hd = pll_value;
        end else if (hold_on && (pll_write || pll_busy)) begin
          check("hold_addr", {58'd0, pll_addr}, {58'd0, ha});
          check("hold_data", {32'd0, pll_value}, {32'd0, hd});
        end else begin
          hold_on = 1'b0;
        end
        if (pll_write) run++;
        else if (prev_wr) begin last_run = run; run = 0; end
        if (done) begin
          check("done_err_excl", {63'd0, err}, 64'd0);
          check("done_width", {63'd0, prev_done}, 64'd0);
          check("writes_before_done", exp_wr.size(), 64'd0);
          if (exp_done == 0) begin
            n_vec++; n_bad++;
            $display("FAIL unexpected_done: got done=1, expected no done");
          end else begin
            exp_done--;
          end
        end
      end
      prev_wr = pll_write;
      prev_done = done;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    for (int c = 0; c < 4000 && !ready; c++) step();
    check(name, {63'd0, ready}, 64'd1);
  endtask

  task automatic issue(input logic [31:0] m, input logic [31:0] n,
                       input logic [31:0] c0, input logic [31:0] k);
    req = 1'b1; m_val = m; n_val = n; c0_val = c0; k_val = k;
    step();
    req = 1'b0;
    check("accept_ready_low", {63'd0, ready}, 64'd0);
    check("accept_err_clear", {63'd0, err}, 64'd0);
    m_val = $urandom; n_val = $urandom; c0_val = $urandom; k_val = $urandom;
  endtask

  task automatic run_seq(input logic [31:0] m, input logic [31:0] n,
                         input logic [31:0] c0, input logic [31:0] k, input bit intrude);
    wait_ready("ready_before_req");
    push_seq(m, n, c0, k, 6);
    exp_done++;
    issue(m, n, c0, k);
    if (intrude) begin
      for (int i = 0; i < 8; i++) begin
        req = 1'b1;
        m_val = ~m; n_val = $urandom; c0_val = ~c0; k_val = $urandom;
        step();
      end
      req = 1'b0;
    end
    wait_ready("seq_end_ready");
    check("seq_err", {63'd0, err}, 64'd0);
    check("seq_writes_left", exp_wr.size(), 64'd0);
    check("seq_done_left", exp_done, 64'd0);
  endtask

  initial begin
    int   base;
    logic saw_wr;
    reset = 1'b1; req = 1'b0;
    m_val = 32'd0; n_val = 32'd0; c0_val = 32'd0; k_val = 32'd0;
    repeat (3) step();
    check("rst_ready", {63'd0, ready}, 64'd0);
    check("rst_write", {63'd0, pll_write}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_err", {63'd0, err}, 64'd0);
    check("rst_addr", {58'd0, pll_addr}, 64'd0);
    check("rst_value", {32'd0, pll_value}, 64'd0);
    reset = 1'b0;
    step();
    check("ready_after_rst", {63'd0, ready}, 64'd1);

    run_seq(32'h0000_0404, $urandom, $urandom, $urandom, 1'b0);
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 5)) step();
      run_seq($urandom, $urandom, $urandom, $urandom, i[0]);
    end

    // PLL busy for 500 cycles before the request.
    busy_force = 1'b1;
    repeat (500) step();
    push_seq(32'h1234_5678, 32'h0000_0101, 32'hCAFE_0001, 32'h0000_0007, 6);
    exp_done++;
    issue(32'h1234_5678, 32'h0000_0101, 32'hCAFE_0001, 32'h0000_0007);
    saw_wr = 1'b0;
    for (int i = 0; i < 30; i++) begin
      saw_wr = saw_wr | pll_write;
      step();
    end
    check("busy_start_no_write", {63'd0, saw_wr}, 64'd0);
    busy_force = 1'b0;
    wait_ready("busy_start_ready");
    check("busy_start_err", {63'd0, err}, 64'd0);
    check("busy_start_left", exp_wr.size(), 64'd0);
    check("busy_start_done_left", exp_done, 64'd0);

    // Busy never rises during the strobe of write 2.
    wait_ready("to_ready_before");
    stuck_at = strobe_no + 2;
    push_seq(32'hAAAA_5555, 32'h0F0F_F0F0, $urandom, $urandom, 2);
    issue(32'hAAAA_5555, 32'h0F0F_F0F0, $urandom, $urandom);
    wait_ready("to_ready_after");
    check("to_err", {63'd0, err}, 64'd1);
    check("to_write", {63'd0, pll_write}, 64'd0);
    check("to_strobe_len", last_run, TO + 1);
    check("to_writes_left", exp_wr.size(), 64'd0);
    stuck = 1'b0;
    stuck_at = 0;
    repeat (5) step();
    check("to_err_held", {63'd0, err}, 64'd1);

    run_seq($urandom, $urandom, $urandom, $urandom, 1'b0);

    // Reset while write 4 is strobing, then a full sequence from address 0.
    base = strobe_no;
    push_seq(32'h0BAD_F00D, 32'h0000_0033, 32'h0000_0044, 32'h0000_0055, 4);
    issue(32'h0BAD_F00D, 32'h0000_0033, 32'h0000_0044, 32'h0000_0055);
    for (int c = 0; c < 4000 && !(strobe_no == base + 4 && pll_write); c++) step();
    check("mid_rst_reached", {63'd0, pll_write}, 64'd1);
    reset = 1'b1;
    step();
    check("mid_rst_write", {63'd0, pll_write}, 64'd0);
    check("mid_rst_ready", {63'd0, ready}, 64'd0);
    check("mid_rst_addr", {58'd0, pll_addr}, 64'd0);
    check("mid_rst_done", {63'd0, done}, 64'd0);
    reset = 1'b0;
    step();
    check("mid_rst_idle", {63'd0, ready}, 64'd1);
    check("mid_rst_left", exp_wr.size(), 64'd0);
    run_seq($urandom, $urandom, $urandom, $urandom, 1'b1);

    repeat (30) step();
    check("final_writes_left", exp_wr.size(), 64'd0);
    check("final_done_left", exp_done, 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
